door_input_cond: RTL

Input conditioning stage directly upstream of `motor_fsm` in the garage-door controller. It takes the raw, asynchronous push-button and limit-switch signals and synchronizes and debounces each one. It produces the clean `activate`, `up_limit` and `dn_limit` inputs that `motor_fsm` consumes. It optionally detects the physically impossible both-limits-closed condition and blocks activation while it holds.

---
 rtl/door_pkg.sv | 14 +
 rtl/debounce_ch.sv | 46 ++++
 rtl/door_input_cond.sv | 76 +++++++
 3 files changed

// File: rtl/door_pkg.sv
// Shared definitions for the garage-door input conditioning and motor control blocks.
package door_pkg;

   localparam int unsigned DOOR_DEBOUNCE_DEFAULT = 4;
   localparam int unsigned DOOR_CNT_W            = 8;
   localparam int unsigned DOOR_NUM_CH           = 3;

   typedef enum logic [1:0] {
      CH_BTN = 2'd0,
      CH_UP  = 2'd1,
      CH_DN  = 2'd2
   } door_ch_e;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-FF synchronizer followed by a consecutive-mismatch debounce counter.
module debounce_ch #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable
);

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The count restarts whenever the synchronized input agrees with the stable value,
   // so it can never exceed the terminal count and never wraps.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == CNT_TC) begin
            stable_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], raw};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/door_input_cond.sv
// Synchronizes and debounces button and limit switches for motor_fsm.
// Define DOOR_LIMIT_FAULT_EN to build the sticky both-limits fault that blocks activation.
module door_input_cond
   import door_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DOOR_DEBOUNCE_DEFAULT,
   parameter int unsigned CNT_W           = DOOR_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   input  logic up_sw_raw,
   input  logic dn_sw_raw,
   output logic activate,
   output logic up_limit,
   output logic dn_limit,
   output logic limit_fault
);

   logic [DOOR_NUM_CH-1:0] raw_vec;
   logic [DOOR_NUM_CH-1:0] stable_vec;
   logic                   btn_prev_q;
   logic                   act_q;
   logic                   flt_d;

   assign raw_vec[CH_BTN] = btn_raw;
   assign raw_vec[CH_UP]  = up_sw_raw;
   assign raw_vec[CH_DN]  = dn_sw_raw;

   for (genvar i = 0; i < DOOR_NUM_CH; i++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw    (raw_vec[i]),
         .stable (stable_vec[i])
      );
   end

`ifdef DOOR_LIMIT_FAULT_EN
   logic flt_q;

   assign flt_d = flt_q | (stable_vec[CH_UP] & stable_vec[CH_DN]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flt_q <= 1'b0;
      end else begin
         flt_q <= flt_d;
      end
   end

   assign limit_fault = flt_q;
`else
   assign flt_d       = 1'b0;
   assign limit_fault = 1'b0;
`endif

   // Gating with the next fault value also kills a pulse on the edge the fault sets.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev_q <= 1'b0;
         act_q      <= 1'b0;
      end else begin
         btn_prev_q <= stable_vec[CH_BTN];
         act_q      <= stable_vec[CH_BTN] & ~btn_prev_q & ~flt_d;
      end
   end

   assign activate = act_q;
   assign up_limit = stable_vec[CH_UP];
   assign dn_limit = stable_vec[CH_DN];

endmodule
